// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Front end of the core. Keeps the program counter, issues one word read per
//   cycle to a synchronous instruction memory (read data returns one clock
//   after the address), and queues the returned words in a small FIFO that is
//   offered to decode with a valid/ready handshake. A redirect reloads the pc
//   and flushes everything fetched so far.
//
// Parameters:
//   RESET_PC  byte address fetched first after reset
//   DEPTH     number of entries in the output instruction buffer (>= 2)
//
// Ports:
//   clk             clock, all state changes on the rising edge
//   rst             synchronous, active-high reset
//   imem_addr       word index to instruction memory, {2'b00, pc[31:2]}
//   imem_data       memory read data, valid one clock after imem_addr
//   redirect_valid  branch/jump redirect request
//   redirect_pc     redirect target byte address (bits [1:0] ignored)
//   out_valid       an instruction is offered to decode
//   out_ready       decode accepts the offered instruction
//   out_pc          byte address of the offered instruction
//   out_instr       offered instruction word
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so buffered + in-flight never wraps in the issue test.
  localparam int OCC_W = CNT_W + 1;

  // Control state (reset)
  logic [31:0]      pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  // Data state (never reset; qualified by the control state above)
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic [31:0]      buf_pc_q    [DEPTH];
  logic [31:0]      buf_instr_q [DEPTH];

  logic             pop;
  logic             push;
  logic             issue;
  logic [OCC_W-1:0] occupancy;

  // Low address bits of a redirect target are architecturally ignored.
  logic             unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Memory address comes straight from the pc register so the memory sees no
  // combinational path from any input of this block.
  assign imem_addr = {2'b00, pc_q[31:2]};

  // Output is always the FIFO head; returned memory data is never bypassed.
  assign out_valid = !rst && (count_q != '0);
  assign out_pc    = out_valid ? buf_pc_q[rd_ptr_q]    : 32'h0;
  assign out_instr = out_valid ? buf_instr_q[rd_ptr_q] : 32'h0;

  always_comb begin
    pop       = out_valid && out_ready;
    occupancy = {1'b0, count_q} + OCC_W'(inflight_q) - OCC_W'(pop);

    // Only fetch when a slot is guaranteed for the response next cycle; this
    // is what keeps the FIFO from ever overflowing.
    issue     = !redirect_valid && (occupancy < OCC_W'(DEPTH));

    // A response arriving during a redirect belongs to the old path.
    push      = inflight_q && !redirect_valid;

    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (issue) begin
      inflight_pc_d = pc_q;
    end

    if (redirect_valid) begin
      // A pop in this cycle still counts as consumed; the flush simply
      // discards whatever remains.
      pc_d     = {redirect_pc[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (issue) begin
        pc_d = pc_q + 32'd4;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
    end
  end

  // ---- fetch stage: pc / in-flight tracking / FIFO pointers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // ---- response stage: capture memory data into the FIFO tail ----
  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    if (push) begin
      buf_pc_q[wr_ptr_q]    <= inflight_pc_q;
      buf_instr_q[wr_ptr_q] <= imem_data;
    end
  end

endmodule
